// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage initiator for a word-addressed data memory (synchronous write,
// combinational read while mem_read=1). Handles byte/halfword/word loads and
// stores coming out of the EX/MEM pipeline register:
//   - byte address -> word index translation for the memory port
//   - lane selection and sign/zero extension of load data (latency 1)
//   - word stores written straight through in a single cycle
//   - byte/half stores done as a two-cycle read-modify-write (one stall cycle)
//   - rejection of misaligned, out-of-range and malformed requests
//
// Ports:
//   clk          in   system clock, all state updates on posedge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   request present this cycle
//   req_read     in   load request
//   req_write    in   store request
//   req_size     in   [1:0] 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned in   1 = zero-extend loads, 0 = sign-extend
//   req_addr     in   [31:0] byte address
//   req_wdata    in   [31:0] store data, right-justified for sub-word sizes
//   stall        out  hold the pipeline (request must stay stable while high)
//   load_data    out  [31:0] extended load result
//   load_valid   out  one-cycle pulse, load_data valid
//   access_err   out  one-cycle pulse, request rejected
//   err_addr     out  [31:0] address of the last rejected request
//   mem_addr     out  [31:0] word index to data memory
//   mem_read     out  MemRead strobe
//   mem_write    out  MemWrite strobe
//   mem_wdata    out  [31:0] writeData to data memory
//   mem_rdata    in   [31:0] readData from data memory
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned DEPTH      = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err,
  output logic [31:0] err_addr,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_RMW_WR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] w_word_idx;
  logic        w_in_range;
  logic        w_aligned;
  logic        w_one_op;
  logic        w_legal;
  logic        w_illegal;
  logic [1:0]  w_byte_lane;
  logic        w_half_lane;

  logic        w_load_fire;
  logic        w_err_fire;
  logic        w_rmw_start;

  logic [31:0] r_rmw_idx_p1;
  logic [31:0] r_rmw_data_p1;

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] f_load_extend(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  blane,
    input logic        hlane,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{blane, 3'b000} +: 8];
    h = word[{hlane, 4'b0000} +: 16];
    case (size)
      SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Insert the low byte/half of the store data into the addressed lane of the
  // current memory word, leaving every other lane untouched.
  function automatic logic [31:0] f_store_merge(
    input logic [31:0] old_word,
    input logic [1:0]  size,
    input logic [1:0]  blane,
    input logic        hlane,
    input logic [31:0] wdata
  );
    logic [31:0] res;
    res = old_word;
    case (size)
      SZ_BYTE: res[{blane, 3'b000} +: 8]  = wdata[7:0];
      SZ_HALF: res[{hlane, 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Request decode
  assign w_word_idx  = {2'b00, req_addr[31:2]};
  assign w_in_range  = (w_word_idx < DEPTH);
  assign w_one_op    = req_read ^ req_write;
  assign w_byte_lane = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
  assign w_half_lane = BIG_ENDIAN ? ~req_addr[1]   : req_addr[1];

  always_comb begin
    w_aligned = 1'b0;
    case (req_size)
      SZ_BYTE: w_aligned = 1'b1;
      SZ_HALF: w_aligned = ~req_addr[0];
      SZ_WORD: w_aligned = (req_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_legal   = req_valid & w_one_op & (req_size != 2'b11) & w_aligned & w_in_range;
  assign w_illegal = req_valid & ~w_legal;

  // Next-state and memory-port control
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = w_word_idx;
    mem_wdata   = req_wdata;
    w_load_fire = 1'b0;
    w_err_fire  = 1'b0;
    w_rmw_start = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_legal) begin
          if (req_read) begin
            mem_read    = 1'b1;
            w_load_fire = 1'b1;
          end else if (req_size == SZ_WORD) begin
            mem_write = 1'b1;
          end else begin
            // Sub-word store: read the old word now, write the merge next cycle.
            mem_read    = 1'b1;
            stall       = 1'b1;
            w_rmw_start = 1'b1;
            w_state_nxt = S_RMW_WR;
          end
        end else if (w_illegal) begin
          w_err_fire = 1'b1;
        end
      end
      S_RMW_WR: begin
        // Request inputs are deliberately ignored here.
        mem_write   = 1'b1;
        mem_addr    = r_rmw_idx_p1;
        mem_wdata   = r_rmw_data_p1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Reset must keep strobes off even before the state register settles, so a
    // read-modify-write caught by reset never commits its write.
    if (!rst_n) begin
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  // Stage p0 -> p1: state, response pulses and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      access_err <= 1'b0;
      err_addr   <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      load_valid <= w_load_fire;
      access_err <= w_err_fire;
      if (w_load_fire) begin
        load_data <= f_load_extend(mem_rdata, req_size, w_byte_lane, w_half_lane, req_unsigned);
      end
      if (w_err_fire) begin
        err_addr <= req_addr;
      end
    end
  end

  // Stage p0 -> p1: read-modify-write payload (only consumed in S_RMW_WR)
  always_ff @(posedge clk) begin
    if (w_rmw_start) begin
      r_rmw_idx_p1  <= w_word_idx;
      r_rmw_data_p1 <= f_store_merge(mem_rdata, req_size, w_byte_lane, w_half_lane, req_wdata);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Bench for mem_access_unit. Contains a 32-word data memory model attached to
// the DUT memory port and a shadow copy of the expected memory contents.
// Expected load results and error addresses are queued as requests are driven
// and popped by a monitor when load_valid / access_err pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;
  logic [31:0] err_addr;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;

  logic [31:0] mem   [0:31] = '{default: 32'h0};
  logic [31:0] model [0:31] = '{default: 32'h0};
  logic [31:0] exp_load_q [$];
  logic [31:0] exp_err_q  [$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(32), .BIG_ENDIAN(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .access_err   (access_err),
    .err_addr     (err_addr),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Data memory: combinational read while MemRead, synchronous write.
  assign mem_rdata = mem_read ? mem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) begin
      n_wr = n_wr + 1;
      if (mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (load_valid) begin
      checks++;
      if (exp_load_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: load_data=%h, no load outstanding", load_data);
      end else begin
        mon_exp = exp_load_q.pop_front();
        if (load_data !== mon_exp) begin
          errors++;
          $display("FAIL load_data: got %h expected %h", load_data, mon_exp);
        end
      end
    end
    if (access_err) begin
      checks++;
      if (exp_err_q.size() == 0) begin
        errors++;
        $display("FAIL err_unexpected: err_addr=%h, no error outstanding", err_addr);
      end else begin
        mon_exp = exp_err_q.pop_front();
        if (err_addr !== mon_exp) begin
          errors++;
          $display("FAIL err_addr: got %h expected %h", err_addr, mon_exp);
        end
      end
    end
    if (load_valid && access_err) begin
      checks++;
      errors++;
      $display("FAIL pulse_overlap: load_valid=1 access_err=1, expected at most one");
    end
    if (mem_read || mem_write) begin
      checks++;
      if ((mem_read && mem_write) || (mem_addr >= 32)) begin
        errors++;
        $display("FAIL strobe_safety: rd=%b wr=%b addr=%h, expected one strobe and index<32",
                 mem_read, mem_write, mem_addr);
      end
    end
  end

  // Reference behaviour written as shift/mask arithmetic
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    case (sz)
      2'b00: begin
        s = (w >> (8 * a[1:0])) & 32'h0000_00FF;
        if (!uns && s[7]) s = s | 32'hFFFF_FF00;
      end
      2'b01: begin
        s = (w >> (16 * a[1])) & 32'h0000_FFFF;
        if (!uns && s[15]) s = s | 32'hFFFF_0000;
      end
      default: s = w;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] m;
    logic [31:0] sh;
    if (sz == 2'b00) begin
      sh = 8 * a[1:0];
      m  = 32'h0000_00FF << sh;
    end else if (sz == 2'b01) begin
      sh = 16 * a[1];
      m  = 32'h0000_FFFF << sh;
    end else begin
      sh = 0;
      m  = 32'hFFFF_FFFF;
    end
    return (old & ~m) | ((d << sh) & m);
  endfunction

  task automatic set_req(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
    req_valid    = v;
    req_read     = rd;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = d;
  endtask

  task automatic clr_req();
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle_cycles(input int n);
    clr_req();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a load; caller supplies the value the load must return.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic [31:0] e, input string tag);
    exp_load_q.push_back(e);
    set_req(1'b1, 1'b1, 1'b0, sz, uns, a, 32'h0);
    #2;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || stall !== 1'b0 || mem_addr !== {2'b00, a[31:2]}) begin
      errors++;
      $display("FAIL %s_issue: rd=%b wr=%b stall=%b idx=%0d, expected rd=1 wr=0 stall=0 idx=%0d",
               tag, mem_read, mem_write, stall, mem_addr, a[31:2]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (load_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: load_valid=%b one cycle after issue, expected 1", tag, load_valid);
    end
    clr_req();
  endtask

  // Issue a store and follow it through to the memory commit.
  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                          input string tag);
    logic [31:0] merged;
    logic [4:0]  idx;
    idx    = a[6:2];
    merged = ref_merge(model[idx], a, sz, d);
    set_req(1'b1, 1'b0, 1'b1, sz, 1'b0, a, d);
    #2;
    if (sz == 2'b10) begin
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || stall !== 1'b0 ||
          mem_addr !== {27'h0, idx} || mem_wdata !== d) begin
        errors++;
        $display("FAIL %s_wstore: wr=%b rd=%b stall=%b idx=%0d wdata=%h, expected wr=1 rd=0 stall=0 idx=%0d wdata=%h",
                 tag, mem_write, mem_read, stall, mem_addr, mem_wdata, idx, d);
      end
      @(posedge clk);
      #1;
    end else begin
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || stall !== 1'b1) begin
        errors++;
        $display("FAIL %s_rmw_rd: rd=%b wr=%b stall=%b, expected rd=1 wr=0 stall=1",
                 tag, mem_read, mem_write, stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || stall !== 1'b0 ||
          mem_addr !== {27'h0, idx} || mem_wdata !== merged) begin
        errors++;
        $display("FAIL %s_rmw_wr: wr=%b rd=%b stall=%b idx=%0d wdata=%h, expected wr=1 rd=0 stall=0 idx=%0d wdata=%h",
                 tag, mem_write, mem_read, stall, mem_addr, mem_wdata, idx, merged);
      end
      @(posedge clk);
      #1;
    end
    model[idx] = merged;
    checks++;
    if (mem[idx] !== merged) begin
      errors++;
      $display("FAIL %s_commit: mem[%0d]=%h expected %h", tag, idx, mem[idx], merged);
    end
    clr_req();
  endtask

  task automatic do_illegal(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input string tag);
    int wr_before;
    wr_before = n_wr;
    exp_err_q.push_back(a);
    set_req(1'b1, rd, wr, sz, 1'b0, a, 32'hA5A5_A5A5);
    #2;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_strobes: rd=%b wr=%b stall=%b, expected all 0", tag, mem_read, mem_write, stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (access_err !== 1'b1 || load_valid !== 1'b0 || n_wr != wr_before) begin
      errors++;
      $display("FAIL %s_err: access_err=%b load_valid=%b writes=%0d, expected 1 0 %0d",
               tag, access_err, load_valid, n_wr, wr_before);
    end
    clr_req();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_5678);
    #2;
    checks++;
    if (stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: stall=%b rd=%b wr=%b, expected 0 0 0", stall, mem_read, mem_write);
    end
    checks++;
    if (load_data !== 32'h0 || load_valid !== 1'b0 || access_err !== 1'b0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: load_data=%h lv=%b ae=%b err_addr=%h, expected all 0",
               load_data, load_valid, access_err, err_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    clr_req();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word_store_byte_load();
    do_store(32'h10, 2'b10, 32'hDEAD_BEEF, "ws_idx4");
    do_load (32'h13, 2'b00, 1'b0, 32'hFFFF_FFDE, "lb_0x13");
    do_load (32'h11, 2'b00, 1'b1, 32'h0000_00BE, "lbu_0x11");
    idle_cycles(1);
  endtask

  task automatic test_half_rmw();
    do_store(32'h08, 2'b10, 32'h1122_3344, "ws_idx2");
    do_store(32'h0A, 2'b01, 32'h0000_ABCD, "sh_0x0A");
    checks++;
    if (mem[2] !== 32'hABCD_3344) begin
      errors++;
      $display("FAIL sh_result: mem[2]=%h expected abcd3344", mem[2]);
    end
    do_load(32'h0A, 2'b01, 1'b1, 32'h0000_ABCD, "lhu_0x0A");
    do_load(32'h0A, 2'b01, 1'b0, 32'hFFFF_ABCD, "lh_0x0A");
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    do_store(32'h04, 2'b10, 32'h0000_0000, "ws_idx1");
    do_store(32'h05, 2'b00, 32'h0000_007F, "sb_0x05");
    do_load (32'h04, 2'b10, 1'b0, 32'h0000_7F00, "lw_after_sb");
    idle_cycles(1);
  endtask

  task automatic test_boundary();
    do_store(32'h7C, 2'b10, 32'hCAFE_F00D, "ws_idx31");
    do_load (32'h7E, 2'b01, 1'b0, 32'hFFFF_CAFE, "lh_0x7E");
    do_load (32'h7F, 2'b00, 1'b1, 32'h0000_00CA, "lbu_0x7F");
    do_store(32'h7C, 2'b00, 32'hFFFF_FF12, "sb_0x7C");
    do_load (32'h7C, 2'b10, 1'b0, 32'hCAFE_F012, "lw_0x7C");
    idle_cycles(1);
  endtask

  task automatic test_illegal();
    do_illegal(1'b1, 1'b0, 2'b10, 32'h0000_0006, "mis_word");
    do_illegal(1'b0, 1'b1, 2'b01, 32'h0000_0003, "mis_half");
    do_illegal(1'b1, 1'b0, 2'b11, 32'h0000_0000, "size11");
    do_illegal(1'b1, 1'b1, 2'b10, 32'h0000_0000, "rd_and_wr");
    do_illegal(1'b0, 1'b0, 2'b10, 32'h0000_0010, "no_op");
    do_illegal(1'b1, 1'b0, 2'b10, 32'h0000_0080, "idx32");
    do_illegal(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFC, "idx_huge");
    idle_cycles(1);
    checks++;
    if (mem[0] !== model[0] || mem[1] !== model[1] || mem[4] !== model[4]) begin
      errors++;
      $display("FAIL illegal_mem: mem[0]=%h mem[1]=%h mem[4]=%h expected %h %h %h",
               mem[0], mem[1], mem[4], model[0], model[1], model[4]);
    end
  endtask

  task automatic test_random_mix();
    for (int i = 8; i < 16; i++) begin
      do_store({25'h0, i[4:0], 2'b00}, 2'b10, $urandom, "rnd_ws");
    end
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        uns;
      sz  = 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a   = {25'h0, 5'($urandom_range(8, 15)), 2'($urandom_range(0, 3))};
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      if (k % 3 == 2) begin
        do_store(a, sz, $urandom, "rnd_st");
      end else begin
        do_load(a, sz, uns, ref_load(model[a[6:2]], a, sz, uns), "rnd_ld");
      end
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_during_rmw();
    int wr_before;
    set_req(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h08, 32'h0000_0055);
    #2;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_rmw_start: stall=%b expected 1", stall);
    end
    @(posedge clk);
    #1;
    wr_before = n_wr;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0 ||
        load_valid !== 1'b0 || access_err !== 1'b0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_rmw_outputs: wr=%b rd=%b stall=%b ld=%h lv=%b ae=%b ea=%h, expected all 0",
               mem_write, mem_read, stall, load_data, load_valid, access_err, err_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (n_wr != wr_before || mem[2] !== model[2]) begin
      errors++;
      $display("FAIL rst_rmw_abandon: writes=%0d mem[2]=%h, expected %0d %h",
               n_wr, mem[2], wr_before, model[2]);
    end
    clr_req();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_load (32'h08, 2'b10, 1'b0, 32'hABCD_3344, "lw_after_rst");
    do_store(32'h08, 2'b00, 32'h0000_0055, "sb_after_rst");
    do_load (32'h08, 2'b10, 1'b0, 32'hABCD_3355, "lw_after_sb");
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_word_store_byte_load();
    test_half_rmw();
    test_back_to_back();
    test_boundary();
    test_illegal();
    test_random_mix();
    test_reset_during_rmw();
    checks++;
    if (exp_load_q.size() != 0 || exp_err_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: loads left=%0d errors left=%0d, expected 0 0",
               exp_load_q.size(), exp_err_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage initiator for the word-addressed data memory (32 x 32-bit, synchronous write on posedge clk, combinational read while MemRead=1).
- Accepts byte/halfword/word load and store requests from the EX/MEM pipeline register.
- Converts byte addresses to word indices and drives the memory's address/MemRead/MemWrite/writeData.
- Extends load data; performs sub-word stores as a 2-cycle read-modify-write, stalling the pipeline for one cycle.
- Flags misaligned, out-of-range and malformed requests.

Parameters:
DEPTH, 32, number of 32-bit words in data memory; word index must be < DEPTH.
BIG_ENDIAN, 0, lane order; 0 = byte at addr[1:0]=0 occupies bits 7:0. Only 0 is required to be supported.

Ports:
clk  input  1  system clock, all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present this cycle.
req_read  input  1  load request.
req_write  input  1  store request.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
req_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-justified for sub-word sizes.
stall  output  1  hold pipeline; upstream must keep the request stable while high.
load_data  output  32  extended load result.
load_valid  output  1  one-cycle pulse, load_data valid.
access_err  output  1  one-cycle pulse, request rejected.
err_addr  output  32  req_addr of the last rejected request.
mem_addr  output  32  word index to data memory: {2'b0, req_addr[31:2]}.
mem_read  output  1  MemRead to data memory.
mem_write  output  1  MemWrite to data memory.
mem_wdata  output  32  writeData to data memory.
mem_rdata  input  32  readData from data memory.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE.
  - load_data = 0, load_valid = 0, access_err = 0, err_addr = 0.
  - stall, mem_read and mem_write are forced to 0 while rst_n=0.
- Legal request: req_valid=1, exactly one of req_read/req_write, req_size != 11, aligned (half: addr[0]=0; word: addr[1:0]=0), and addr[31:2] < DEPTH. Any other request with req_valid=1 is illegal.
- Illegal request:
  - No memory access (mem_read=0, mem_write=0).
  - Next edge: access_err=1 for one cycle, err_addr=req_addr.
  - stall=0.
- States: IDLE and RMW_WR.
- IDLE, legal load:
  - Combinationally mem_read=1, mem_addr = word index.
  - Next edge: load_data = selected lane of mem_rdata, extended per req_unsigned. load_valid=1 for one cycle.
  - Latency 1, stall=0.
  - Lane select: byte lane = addr[1:0]; half lane = addr[1].
- IDLE, legal word store:
  - Combinationally mem_write=1, mem_wdata=req_wdata; memory commits at the same edge.
  - stall=0; remain in IDLE.
- IDLE, legal byte/half store (cycle 1 of RMW):
  - mem_read=1, stall=1.
  - Merge: mem_rdata with the req_wdata low byte/half inserted at the addressed lane; other lanes unchanged.
  - Register merged word and word index; go to RMW_WR.
- RMW_WR (cycle 2):
  - mem_write=1, mem_addr = registered index, mem_wdata = registered merged word, stall=0.
  - Request inputs are ignored; return to IDLE next edge.
- load_valid and access_err are never high in the same cycle. mem_read and mem_write are never high together.
- Back-to-back requests: a load issued the cycle after RMW_WR reads the newly written word (write committed at the RMW_WR edge). No forwarding is needed.
- req_valid=0: no memory strobes; pulses deassert next edge.
- Reset asserted in RMW_WR: the write is abandoned; memory keeps its old word (mem_write forced low before the edge); state returns to IDLE.
- Address index above DEPTH-1 never reaches the memory.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF; then signed byte load addr 0x13 -> stall stays 0; mem_write pulse at index 4; next cycle load_valid=1, load_data=0xFFFFFFDE.
- Word 0x11223344 at index 2; half store addr 0x0A data 0xABCD -> stall=1 for exactly 1 cycle; RMW_WR writes 0xABCD3344; following unsigned half load addr 0x0A returns 0x0000ABCD.
- Byte store addr 0x05 data 0x7F over word 0x00000000, immediately followed by a word load addr 0x04 -> load_data=0x00007F00, no stale data.
- Misaligned word load addr 0x06; half store addr 0x03; size 11; read+write both set; addr 0x80 (index 32) -> each gives access_err pulse, err_addr equals input, no mem strobes, memory unchanged.
- rst_n pulled low during RMW_WR of byte store addr 0x08 -> mem_write never high, word at index 2 unchanged, all outputs 0, next request serviced normally.
